// File: rtl/vga_mem_responder.sv
// Double-buffered frame memory arbiter: VGA scan-out reads (two-cycle latency,
// absolute priority) share one memory port with a 4-deep pixel write queue.
module vga_mem_responder #(
    parameter int LOG_MEM     = 36,
    parameter int LOG_HCOUNT  = 10,
    parameter int LOG_VCOUNT  = 10,
    parameter int LOG_ADDR    = 19,
    parameter int FRAME_WORDS = 153600
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] hcount,
    input  logic [LOG_VCOUNT-1:0] vcount,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    input  logic                  wr_req,
    input  logic [17:0]           wr_addr,
    input  logic [LOG_MEM-1:0]    wr_data,
    output logic                  wr_ready,
    output logic [LOG_ADDR-1:0]   mem_addr,
    output logic                  mem_we,
    output logic [LOG_MEM-1:0]    mem_wdata,
    input  logic [LOG_MEM-1:0]    mem_rdata,
    output logic                  display_buf,
    output logic                  err_addr
);

    localparam int WA_W  = 18;
    localparam int DEPTH = 4;

    localparam logic [LOG_HCOUNT-1:0] H_ACTIVE  = LOG_HCOUNT'(640);
    localparam logic [LOG_VCOUNT-1:0] V_ACTIVE  = LOG_VCOUNT'(480);
    localparam logic [LOG_ADDR-1:0]   BUF1_BASE = LOG_ADDR'(FRAME_WORDS);
    localparam logic [WA_W-1:0]       WA_LIMIT  = WA_W'(FRAME_WORDS);

    // Registered state
    logic                 display_buf_q, display_buf_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 err_addr_q, err_addr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_hit_q, rd_hit_d;
    logic                 done_q, done_d;
    logic [LOG_MEM-1:0]   vga_pixel_q, vga_pixel_d;
    logic [1:0]           head_q, head_d;
    logic [1:0]           tail_q, tail_d;
    logic [2:0]           count_q, count_d;
    logic [WA_W-1:0]      fifo_addr_q [DEPTH];
    logic [LOG_MEM-1:0]   fifo_data_q [DEPTH];

    // Combinational helpers
    logic                 rd_req;
    logic                 rd_hit;
    logic                 swap_now;
    logic                 buf_sel;
    logic                 push;
    logic                 pop;
    logic                 head_bad;
    logic [WA_W-1:0]      head_addr;
    logic [LOG_MEM-1:0]   head_data;
    logic [LOG_ADDR-1:0]  v_ext;
    logic [LOG_ADDR-1:0]  h_ext;
    logic [LOG_ADDR-1:0]  rd_offset;
    logic                 unused_hcount_lsb;

    function automatic logic [LOG_ADDR-1:0] buf_base(input logic sel);
        return sel ? BUF1_BASE : '0;
    endfunction

    assign unused_hcount_lsb = hcount[0];

    // Read decode and buffer swap; the (0,0) read that performs the swap
    // already addresses the new display buffer.
    always_comb begin
        rd_req    = vga_flag & ~reset;
        rd_hit    = rd_req && (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
        swap_now  = rd_hit && (hcount == '0) && (vcount == '0)
                    && (swap_pending_q || frame_flag);
        buf_sel   = display_buf_q ^ swap_now;
        v_ext     = LOG_ADDR'(vcount);
        h_ext     = LOG_ADDR'(hcount[LOG_HCOUNT-1:1]);
        rd_offset = (v_ext << 8) + (v_ext << 6) + h_ext;  // vcount*320
    end

    // Write queue control; readiness depends only on registered occupancy.
    always_comb begin
        wr_ready  = ~reset && (count_q != 3'(DEPTH));
        push      = wr_req && wr_ready;
        pop       = ~reset && (count_q != '0) && ~rd_hit;
        head_addr = fifo_addr_q[head_q];
        head_data = fifo_data_q[head_q];
        head_bad  = head_addr >= WA_LIMIT;
        head_d    = head_q + 2'(pop);
        tail_d    = tail_q + 2'(push);
        count_d   = count_q + 3'(push) - 3'(pop);
    end

    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        err_addr_d     = err_addr_q;
        display_buf_d  = buf_sel;
        swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | frame_flag);
        if (rd_hit) begin
            mem_addr = buf_base(buf_sel) + rd_offset;
        end else if (pop) begin
            if (head_bad) begin
                err_addr_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_addr  = buf_base(~buf_sel) + LOG_ADDR'(head_addr);
                mem_wdata = head_data;
            end
        end
    end

    // Read return pipeline: address in t, data in t+1, result visible in t+2.
    always_comb begin
        rd_valid_d  = rd_req;
        rd_hit_d    = rd_hit;
        done_d      = rd_valid_q;
        vga_pixel_d = vga_pixel_q;
        if (rd_valid_q) begin
            vga_pixel_d = rd_hit_q ? mem_rdata : '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            display_buf_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            err_addr_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_hit_q       <= 1'b0;
            done_q         <= 1'b0;
            vga_pixel_q    <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
        end else begin
            display_buf_q  <= display_buf_d;
            swap_pending_q <= swap_pending_d;
            err_addr_q     <= err_addr_d;
            rd_valid_q     <= rd_valid_d;
            rd_hit_q       <= rd_hit_d;
            done_q         <= done_d;
            vga_pixel_q    <= vga_pixel_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
        end
    end

    // NOTE: queue storage is not reset; the pointers and occupancy alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[tail_q] <= wr_addr;
            fifo_data_q[tail_q] <= wr_data;
        end
    end

    assign done_vga    = done_q & ~reset;
    assign vga_pixel   = reset ? '0 : vga_pixel_q;
    assign display_buf = display_buf_q & ~reset;
    assign err_addr    = err_addr_q & ~reset;

endmodule

// File: tb/tb_vga_mem_responder.sv
// Self-checking bench for vga_mem_responder: a behavioural memory plus
// read/write scoreboards checked every cycle, and one task per scenario.
module tb_vga_mem_responder;

    localparam int FRAME_WORDS = 153600;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_flag = 1'b0;
    logic        vga_flag = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [35:0] wr_data = '0;
    logic [35:0] mem_rdata = '0;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        wr_ready;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata;
    logic        display_buf;
    logic        err_addr;

    vga_mem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .frame_flag  (frame_flag),
        .vga_flag    (vga_flag),
        .hcount      (hcount),
        .vcount      (vcount),
        .vga_pixel   (vga_pixel),
        .done_vga    (done_vga),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .display_buf (display_buf),
        .err_addr    (err_addr)
    );

    always #5 clock = ~clock;

    function automatic logic [35:0] pattern(input logic [18:0] a);
        if (a == 19'd642) return 36'hABC;
        return {17'h15A5A, a};
    endfunction

    function automatic logic [18:0] base_of(input bit b);
        return b ? 19'(FRAME_WORDS) : 19'd0;
    endfunction

    // Memory model: read data for the address of the previous cycle.
    always @(posedge clock) mem_rdata <= pattern(mem_addr);

    typedef struct { logic [35:0] pix; int due; } rd_exp_t;
    typedef struct { logic [17:0] addr; logic [35:0] data; } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];
    int      cyc = 0;
    int      n_checks = 0;
    int      n_pass = 0;
    bit      disp_m = 1'b0;
    bit      pend_m = 1'b0;
    bit      err_m = 1'b0;

    logic        s_we, s_ready, s_done, s_disp, s_err;
    logic [18:0] s_addr;
    logic [35:0] s_wdata, s_pix;

    // Samples the current cycle (inputs already driven), checks it against the
    // model, then advances to 1 ns after the next rising edge.
    task automatic cycle();
        bit          inr;
        bit          exp_ready;
        bit          ok;
        logic [18:0] exp_a;
        wr_exp_t     w;
        rd_exp_t     r;
        #1;
        s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_ready = wr_ready;
        s_done = done_vga; s_pix = vga_pixel; s_disp = display_buf; s_err = err_addr;
        if (reset) begin
            rq.delete(); wq.delete();
            disp_m = 1'b0; pend_m = 1'b0; err_m = 1'b0;
        end
        n_checks++;
        if (display_buf !== disp_m || err_addr !== err_m)
            $display("FAIL state cyc=%0d got display_buf=%b err_addr=%b want %b %b",
                     cyc, display_buf, err_addr, disp_m, err_m);
        else n_pass++;
        if (done_vga === 1'b1 || (rq.size() != 0 && rq[0].due == cyc)) begin
            n_checks++;
            if (rq.size() == 0) begin
                $display("FAIL read_done cyc=%0d got unexpected done_vga pixel=%h want no done",
                         cyc, vga_pixel);
            end else begin
                r = rq.pop_front();
                if (done_vga !== 1'b1 || r.due != cyc || vga_pixel !== r.pix)
                    $display("FAIL read_done cyc=%0d got done=%b pixel=%h want done in cyc %0d pixel=%h",
                             cyc, done_vga, vga_pixel, r.due, r.pix);
                else n_pass++;
            end
        end
        exp_ready = !reset && (wq.size() != 4);
        n_checks++;
        if (wr_ready !== exp_ready)
            $display("FAIL wr_ready cyc=%0d got %b want %b", cyc, wr_ready, exp_ready);
        else n_pass++;
        inr = !reset && vga_flag && hcount < 10'd640 && vcount < 10'd480;
        if (!reset) begin
            if (inr && hcount == 10'd0 && vcount == 10'd0 && (pend_m || frame_flag)) begin
                disp_m = !disp_m;
                pend_m = 1'b0;
            end else if (frame_flag) begin
                pend_m = 1'b1;
            end
        end
        exp_a = '0;
        n_checks++;
        ok = 1'b1;
        if (inr) begin
            exp_a = base_of(disp_m) + 19'(vcount) * 19'd320 + 19'(hcount / 10'd2);
            if (mem_we !== 1'b0 || mem_addr !== exp_a) ok = 1'b0;
        end else if (wq.size() != 0) begin
            w = wq.pop_front();
            if (w.addr >= 18'(FRAME_WORDS)) begin
                err_m = 1'b1;
                if (mem_we !== 1'b0) ok = 1'b0;
            end else begin
                exp_a = base_of(!disp_m) + 19'(w.addr);
                if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== w.data) ok = 1'b0;
            end
        end else begin
            if (mem_we !== 1'b0 || mem_addr !== 19'd0 || mem_wdata !== 36'd0) ok = 1'b0;
        end
        if (!ok)
            $display("FAIL mem_port cyc=%0d got we=%b addr=%0d wdata=%h want addr %0d",
                     cyc, mem_we, mem_addr, mem_wdata, exp_a);
        else n_pass++;
        if (vga_flag && !reset) rq.push_back('{inr ? pattern(exp_a) : 36'd0, cyc + 2});
        if (wr_req && exp_ready) wq.push_back('{wr_addr, wr_data});
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        frame_flag = 1'b0; vga_flag = 1'b0; wr_req = 1'b0;
        hcount = '0; vcount = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vga_flag = 1'b1; hcount = 10'd3; vcount = 10'd3;
        wr_req = 1'b1; wr_addr = 18'd5; frame_flag = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (s_ready !== 1'b0 || s_we !== 1'b0 || s_done !== 1'b0)
            $display("FAIL reset_hold got ready=%b we=%b done=%b want 0 0 0", s_ready, s_we, s_done);
        else n_pass++;
        idle_inputs();
        reset = 1'b0;
        cycle();
        n_checks++;
        if (s_ready !== 1'b1 || s_disp !== 1'b0 || s_done !== 1'b0 || s_pix !== 36'd0
            || s_err !== 1'b0 || s_we !== 1'b0)
            $display("FAIL reset_exit got ready=%b disp=%b done=%b pix=%h err=%b we=%b want 1 0 0 0 0 0",
                     s_ready, s_disp, s_done, s_pix, s_err, s_we);
        else n_pass++;
    endtask

    task automatic test_read();
        vga_flag = 1'b1; hcount = 10'd5; vcount = 10'd2;
        cycle();
        n_checks++;
        if (s_addr !== 19'd642 || s_we !== 1'b0)
            $display("FAIL read_addr got addr=%0d we=%b want 642 0", s_addr, s_we);
        else n_pass++;
        idle_inputs();
        cycle();
        cycle();
        n_checks++;
        if (s_done !== 1'b1 || s_pix !== 36'hABC)
            $display("FAIL read_data got done=%b pixel=%h want 1 abc", s_done, s_pix);
        else n_pass++;
        cycle();
        n_checks++;
        if (s_done !== 1'b0 || s_pix !== 36'hABC)
            $display("FAIL read_hold got done=%b pixel=%h want 0 abc", s_done, s_pix);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hs[8] = '{0, 639, 2, 3, 640, 100, 639, 0};
        int vs[8] = '{0, 479, 0, 0, 0, 480, 1, 7};
        int nd = 0;
        for (int i = 0; i < 8; i++) begin
            vga_flag = 1'b1; hcount = 10'(hs[i]); vcount = 10'(vs[i]);
            cycle();
            if (s_done === 1'b1) nd++;
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (s_done === 1'b1) nd++;
        end
        n_checks++;
        if (nd != 8 || rq.size() != 0)
            $display("FAIL b2b_count got %0d dones (%0d outstanding) want 8 (0)", nd, rq.size());
        else n_pass++;
    endtask

    task automatic test_swap();
        frame_flag = 1'b1;
        cycle();
        frame_flag = 1'b0;
        cycle();
        frame_flag = 1'b1;
        cycle();
        frame_flag = 1'b0;
        vga_flag = 1'b1; hcount = 10'd0; vcount = 10'd0;
        cycle();
        n_checks++;
        if (s_addr !== 19'd153600)
            $display("FAIL swap_read got addr=%0d want 153600", s_addr);
        else n_pass++;
        idle_inputs();
        cycle();
        n_checks++;
        if (s_disp !== 1'b1) $display("FAIL swap_buf got display_buf=%b want 1", s_disp);
        else n_pass++;
        wr_req = 1'b1; wr_addr = 18'd7; wr_data = 36'h123456789;
        cycle();
        wr_req = 1'b0;
        cycle();
        n_checks++;
        if (s_we !== 1'b1 || s_addr !== 19'd7 || s_wdata !== 36'h123456789)
            $display("FAIL swap_write got we=%b addr=%0d data=%h want 1 7 123456789", s_we, s_addr, s_wdata);
        else n_pass++;
        vga_flag = 1'b1;
        cycle();
        n_checks++;
        if (s_addr !== 19'd153600)
            $display("FAIL no_double_swap got addr=%0d want 153600", s_addr);
        else n_pass++;
        frame_flag = 1'b1;
        cycle();
        n_checks++;
        if (s_addr !== 19'd0 || s_we !== 1'b0)
            $display("FAIL same_cycle_swap got addr=%0d we=%b want 0 0", s_addr, s_we);
        else n_pass++;
        idle_inputs();
        cycle();
        n_checks++;
        if (s_disp !== 1'b0) $display("FAIL swap_back got display_buf=%b want 0", s_disp);
        else n_pass++;
        cycle();
    endtask

    task automatic test_contention();
        int  nwe = 0;
        logic ready4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vga_flag = 1'b1; hcount = 10'(10 * i); vcount = 10'd20;
            wr_req = (i < 5); wr_addr = 18'(100 + i); wr_data = 36'hC0DE0000 + 36'(i);
            cycle();
            if (s_we === 1'b1) nwe++;
            if (i == 4) ready4 = s_ready;
        end
        n_checks++;
        if (nwe != 0) $display("FAIL contention_we got %0d writes during reads want 0", nwe);
        else n_pass++;
        n_checks++;
        if (ready4 !== 1'b0) $display("FAIL contention_full got wr_ready=%b want 0", ready4);
        else n_pass++;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (s_we !== 1'b1 || s_addr !== 19'(FRAME_WORDS + 100 + i)
                || s_wdata !== 36'hC0DE0000 + 36'(i))
                $display("FAIL contention_drain%0d got we=%b addr=%0d data=%h want 1 %0d %h",
                         i, s_we, s_addr, s_wdata, FRAME_WORDS + 100 + i, 36'hC0DE0000 + 36'(i));
            else n_pass++;
        end
        cycle();
        n_checks++;
        if (s_we !== 1'b0) $display("FAIL contention_fifth got we=%b want 0", s_we);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        wr_req = 1'b1; wr_addr = 18'd20; wr_data = 36'hF00D;
        cycle();
        wr_req = 1'b0;
        vga_flag = 1'b1; hcount = 10'd700; vcount = 10'd10;
        cycle();
        n_checks++;
        if (s_we !== 1'b1 || s_addr !== 19'(FRAME_WORDS + 20))
            $display("FAIL oor_write got we=%b addr=%0d want 1 %0d", s_we, s_addr, FRAME_WORDS + 20);
        else n_pass++;
        idle_inputs();
        cycle();
        cycle();
        n_checks++;
        if (s_done !== 1'b1 || s_pix !== 36'd0)
            $display("FAIL oor_result got done=%b pixel=%h want 1 0", s_done, s_pix);
        else n_pass++;
    endtask

    task automatic test_bad_addr();
        wr_req = 1'b1; wr_addr = 18'(FRAME_WORDS); wr_data = 36'hBAD;
        cycle();
        wr_req = 1'b0;
        cycle();
        n_checks++;
        if (s_we !== 1'b0) $display("FAIL bad_addr_we got we=%b want 0", s_we);
        else n_pass++;
        cycle();
        n_checks++;
        if (s_err !== 1'b1) $display("FAIL bad_addr_err got err_addr=%b want 1", s_err);
        else n_pass++;
        wr_req = 1'b1; wr_addr = 18'd9; wr_data = 36'h9;
        cycle();
        wr_req = 1'b0;
        cycle();
        n_checks++;
        if (s_we !== 1'b1 || s_err !== 1'b1)
            $display("FAIL bad_addr_after got we=%b err=%b want 1 1", s_we, s_err);
        else n_pass++;
        repeat (3) cycle();
        n_checks++;
        if (s_err !== 1'b1) $display("FAIL bad_addr_sticky got err_addr=%b want 1", s_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int nwe = 0;
        for (int i = 0; i < 3; i++) begin
            vga_flag = 1'b1; hcount = 10'(i); vcount = 10'd5;
            wr_req = 1'b1; wr_addr = 18'(50 + i); wr_data = 36'(i);
            cycle();
        end
        idle_inputs();
        reset = 1'b1;
        cycle();
        n_checks++;
        if (s_done !== 1'b0) $display("FAIL reset_mid_done got done=%b want 0", s_done);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_done === 1'b1) nd++;
            if (s_we === 1'b1) nwe++;
        end
        n_checks++;
        if (nd != 0 || nwe != 0 || s_err !== 1'b0)
            $display("FAIL reset_mid_flush got dones=%0d writes=%0d err=%b want 0 0 0", nd, nwe, s_err);
        else n_pass++;
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_read();
        test_back_to_back();
        test_swap();
        test_contention();
        test_out_of_range();
        test_bad_addr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
